// File: rtl/flip_mask_builder.sv
// flip_mask_builder: gathers the spin-flip indices picked during one annealing
// step into an XOR flip mask. On commit it presents the mask for exactly one
// cycle together with an enable pulse, so the downstream state register
// applies every flip of the step in a single clock.
module flip_mask_builder #(
  parameter int N         = 1024,
  parameter int IDX_W     = 10,
  parameter int MAX_FLIPS = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idx_valid,
  output logic             idx_ready,
  input  logic [IDX_W-1:0] idx,
  input  logic             commit,
  output logic [N-1:0]     mask_out,
  output logic             mask_en,
  output logic [CNT_W-1:0] flip_count,
  output logic             err_oob
);

  typedef enum logic {ACCUM = 1'b0, EMIT = 1'b1} state_t;

  state_t           r_state;
  logic [N-1:0]     r_acc;
  logic [N-1:0]     r_mask;
  logic             r_en;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic             w_accept;
  logic             w_in_range;
  logic [N-1:0]     w_onehot;
  logic [N-1:0]     w_acc_next;
  logic [CNT_W-1:0] w_cnt_next;

  // Ready depends only on registered state; held low while reset is applied
  // so nothing is accepted on the reset edge.
  assign idx_ready  = ~rst && (r_state == ACCUM) && (r_cnt < CNT_W'(MAX_FLIPS));
  assign w_accept   = idx_valid & idx_ready;

  // Indices at or beyond N contribute nothing to the mask but still use a slot.
  assign w_in_range = ({{(32-IDX_W){1'b0}}, idx} < 32'(N));
  assign w_onehot   = w_in_range ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;

  // Same-cycle accept is folded into the values used by a commit.
  assign w_acc_next = w_accept ? (r_acc ^ w_onehot) : r_acc;
  assign w_cnt_next = r_cnt + CNT_W'(w_accept);

  // Step FSM: accumulate flips, then emit the mask for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_mask  <= '0;
      r_en    <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          r_acc <= w_acc_next;
          r_cnt <= w_cnt_next;
          if (w_accept && !w_in_range) r_err <= 1'b1;
          // An empty step (no flips so far and none arriving now) emits nothing.
          if (commit && ((r_cnt != '0) || w_accept)) begin
            r_state <= EMIT;
            r_mask  <= w_acc_next;
            r_en    <= 1'b1;
          end
        end
        EMIT: begin
          // Count stays visible during the pulse and clears with the mask.
          r_state <= ACCUM;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_mask  <= '0;
          r_en    <= 1'b0;
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign mask_out   = r_mask;
  assign mask_en    = r_en;
  assign flip_count = r_cnt;
  assign err_oob    = r_err;

endmodule
